fir_mac_datapath: RTL and testbench
===================================

Name: fir_mac_datapath

Overview:
MAC datapath for the 3-tap FIR. It sits directly downstream of the FIR control sequencer and consumes its control outputs each cycle: RAM write, the ld1/ld2 operand loads, RAM/ROM addresses and the accumulator clear. It holds the sample RAM and the coefficient ROM, and runs a 2-stage multiply/accumulate pipeline. On each clear that closes a sum, it registers the finished filter output with a one-cycle valid pulse.

Parameters:
DATA_W, 8, signed sample width (x_in, sample RAM, x_reg)
COEF_W, 8, signed coefficient width
ACC_W, 18, signed accumulator and y_out width; must be >= DATA_W+COEF_W+2
COEF0, 1, signed ROM word at address 0
COEF1, 2, signed ROM word at address 1
COEF2, 3, signed ROM word at address 2

Ports:
clk  in  1  clock, all state on rising edge
global_reset  in  1  asynchronous, active-high reset
x_in  in  DATA_W  signed input sample to be written
wr  in  1  write x_in into sample RAM[add_ram]
add_ram  in  2  sample RAM address (write and read)
add_rom  in  2  coefficient ROM address
ld1  in  1  load x_reg <= RAM[add_ram]
ld2  in  1  load c_reg <= ROM[add_rom]
acc_clr  in  1  synchronous accumulator clear / sum close
y_out  out  ACC_W  last completed filter output, signed
y_valid  out  1  one-cycle pulse when y_out updates
ovf  out  1  sticky overflow flag for the current sum

Behaviour:
- Reset (async): RAM[0..2], x_reg, c_reg, p_reg, p_vld, acc, pending, y_out, y_valid and ovf all go to 0. A reset mid-sum discards the partial sum and issues no y_valid.
- Sample RAM: 3 words. If wr=1 and add_ram<3, RAM[add_ram] <= x_in on the edge. add_ram=3: the write is dropped and the read returns 0.
- RAM read is combinational from current contents. If wr and ld1 are both asserted at the same address, x_reg gets the old word (read-before-write).
- ROM: combinational. add_rom 0/1/2 returns COEF0/COEF1/COEF2; add_rom=3 returns 0.
- Stage 1: ld1 loads x_reg and ld2 loads c_reg, independently. A register holds its value when its load is low.
- Stage 2: p_vld <= ld1 & ld2 (registered). p_reg <= x_reg * c_reg every cycle (signed, full DATA_W+COEF_W width, sign-extended to ACC_W).
- Latency: ld1=ld2=1 sampled at edge k; the product enters acc at edge k+2.
- Stage 3, evaluated per edge:
  - acc_clr=0, p_vld=1: acc <= acc + p_reg; pending <= 1.
  - acc_clr=0, p_vld=0: acc and pending hold.
  - acc_clr=1, p_vld=0: acc <= 0; pending <= 0.
  - acc_clr=1, p_vld=1: acc <= p_reg; pending <= 1. The clear wins over the old sum and the new sum starts with this product.
- Output capture: on any edge with acc_clr=1 and pending=1, y_out <= acc (the pre-clear value) and y_valid <= 1. Otherwise y_valid <= 0 and y_out holds.
- acc_clr with pending=0 produces no pulse. This covers repeated clears and clears straight after reset.
- Arithmetic: two's complement, wraps modulo 2^ACC_W (default build).
- ovf is set when an accumulate overflows signed ACC_W. It clears on acc_clr, or is reloaded from the p_reg load when acc_clr and p_vld coincide, which cannot overflow.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: FIR_MAC_SAT_EN.
- Defined: an overflowing accumulate clamps acc to +(2^(ACC_W-1)-1) or -2^(ACC_W-1), matching the operand signs, and sets ovf. Further accumulates keep saturating.
- Undefined: acc wraps and ovf still flags the wrap.
- Port list is identical in both builds.

Test Plan:
- Reset then idle 10 cycles -> y_out=0, y_valid=0, ovf=0 throughout. acc_clr pulses during idle -> no y_valid.
- Write x=5,6,7 to add_ram 0,1,2. Load pairs (ram0,rom0), (ram1,rom1), (ram2,rom2) on consecutive cycles, then acc_clr -> y_out=38, y_valid high for exactly 1 cycle; acc=0 after.
- Same loads, with acc_clr asserted on the cycle the last product is valid -> y_out=17 (5+12), new sum starts at 21. A following clear -> y_out=21.
- wr and ld1 at the same address in the same cycle (RAM0=5, x_in=9) with rom0 -> product 5. A later read of RAM0 returns 9.
- add_ram=3 with wr=1 -> RAM unchanged. ld1 at add_ram=3 and ld2 at add_rom=3 -> product 0, acc unchanged in value.
- DATA_W=8, COEF0=127, ACC_W=16: accumulate x=127 three times -> wrapped sum and ovf=1 (default build); 32767 with ovf=1 (FIR_MAC_SAT_EN). global_reset mid-sum -> all outputs 0, no y_valid.

Source files
------------

// File: rtl/fir_mac_datapath.sv
// fir_mac_datapath: sample RAM, coefficient ROM and a 2-stage MAC pipeline
// for the 3-tap FIR. The finished sum is captured on each closing acc_clr.
// Build option: define FIR_MAC_SAT_EN to make overflowing accumulates
// saturate instead of wrapping (ovf flags the event in both builds).
module fir_mac_datapath #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int ACC_W  = 18,
  parameter int COEF0  = 1,
  parameter int COEF1  = 2,
  parameter int COEF2  = 3
) (
  input  logic              clk,
  input  logic              global_reset,
  input  logic [DATA_W-1:0] x_in,
  input  logic              wr,
  input  logic [1:0]        add_ram,
  input  logic [1:0]        add_rom,
  input  logic              ld1,
  input  logic              ld2,
  input  logic              acc_clr,
  output logic [ACC_W-1:0]  y_out,
  output logic              y_valid,
  output logic              ovf
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [DATA_W-1:0] ram0, ram1, ram2, ram_rd;
  logic signed [COEF_W-1:0] rom_rd;
  logic signed [DATA_W-1:0] x_reg;
  logic signed [COEF_W-1:0] c_reg;
  logic                     ld_vld;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  p_reg;
  logic                     p_vld;
  logic signed [ACC_W-1:0]  acc, acc_d, sum;
  logic                     pending, pending_d;
  logic                     ovf_d, add_ovf;

  // Combinational sample RAM read; address 3 is unmapped and reads zero.
  always_comb begin
    ram_rd = '0;
    case (add_ram)
      2'd0:    ram_rd = ram0;
      2'd1:    ram_rd = ram1;
      2'd2:    ram_rd = ram2;
      default: ram_rd = '0;
    endcase
  end

  // Coefficient ROM; address 3 reads zero.
  always_comb begin
    rom_rd = '0;
    case (add_rom)
      2'd0:    rom_rd = COEF_W'(COEF0);
      2'd1:    rom_rd = COEF_W'(COEF1);
      2'd2:    rom_rd = COEF_W'(COEF2);
      default: rom_rd = '0;
    endcase
  end

  // RAM writes and stage-1 operand loads; loads see the pre-write RAM word.
  always_ff @(posedge clk or posedge global_reset) begin
    if (global_reset) begin
      ram0   <= '0;
      ram1   <= '0;
      ram2   <= '0;
      x_reg  <= '0;
      c_reg  <= '0;
      ld_vld <= 1'b0;
    end else begin
      if (wr) begin
        case (add_ram)
          2'd0:    ram0 <= x_in;
          2'd1:    ram1 <= x_in;
          2'd2:    ram2 <= x_in;
          default: ;
        endcase
      end
      if (ld1) x_reg <= ram_rd;
      if (ld2) c_reg <= rom_rd;
      ld_vld <= ld1 & ld2;
    end
  end

  assign prod = x_reg * c_reg;

  // Stage 2: product register; the valid flag trails the load by one more
  // edge so it lines up with the product it qualifies.
  always_ff @(posedge clk or posedge global_reset) begin
    if (global_reset) begin
      p_reg <= '0;
      p_vld <= 1'b0;
    end else begin
      p_reg <= {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
      p_vld <= ld_vld;
    end
  end

  assign sum     = acc + p_reg;
  assign add_ovf = (acc[ACC_W-1] == p_reg[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);

  // Stage 3 next-state: clear/restart, accumulate with overflow tracking, or hold.
  always_comb begin
    acc_d     = acc;
    pending_d = pending;
    ovf_d     = ovf;
    if (acc_clr) begin
      acc_d     = p_vld ? p_reg : '0;
      pending_d = p_vld;
      ovf_d     = 1'b0;
    end else if (p_vld) begin
      pending_d = 1'b1;
      ovf_d     = ovf | add_ovf;
`ifdef FIR_MAC_SAT_EN
      if (add_ovf) acc_d = acc[ACC_W-1] ? ACC_MIN : ACC_MAX;
      else         acc_d = sum;
`else
      acc_d = sum;
`endif
    end
  end

  // Stage 3 accumulator state registers.
  always_ff @(posedge clk or posedge global_reset) begin
    if (global_reset) begin
      acc     <= '0;
      pending <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      acc     <= acc_d;
      pending <= pending_d;
      ovf     <= ovf_d;
    end
  end

  // Capture the pre-clear sum and pulse y_valid when a clear closes a sum.
  always_ff @(posedge clk or posedge global_reset) begin
    if (global_reset) begin
      y_out   <= '0;
      y_valid <= 1'b0;
    end else if (acc_clr && pending) begin
      y_out   <= acc;
      y_valid <= 1'b1;
    end else begin
      y_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_mac_datapath.sv
// Directed testbench for fir_mac_datapath: default instance plus a
// narrow-accumulator instance (ACC_W=16, COEF0=127) for overflow behaviour.
module tb_fir_mac_datapath;

  logic        clk = 1'b0;
  logic        global_reset = 1'b0;
  logic [7:0]  x_in = '0;
  logic        wr = 1'b0;
  logic [1:0]  add_ram = '0;
  logic [1:0]  add_rom = '0;
  logic        ld1 = 1'b0;
  logic        ld2 = 1'b0;
  logic        acc_clr = 1'b0;
  logic [17:0] y_out;
  logic        y_valid;
  logic        ovf;
  logic [15:0] yw_out;
  logic        yw_valid;
  logic        ovfw;

  int checks = 0;
  int failures = 0;

  fir_mac_datapath dut (
    .clk(clk), .global_reset(global_reset), .x_in(x_in), .wr(wr),
    .add_ram(add_ram), .add_rom(add_rom), .ld1(ld1), .ld2(ld2),
    .acc_clr(acc_clr), .y_out(y_out), .y_valid(y_valid), .ovf(ovf)
  );

  fir_mac_datapath #(.ACC_W(16), .COEF0(127)) dut_w (
    .clk(clk), .global_reset(global_reset), .x_in(x_in), .wr(wr),
    .add_ram(add_ram), .add_rom(add_rom), .ld1(ld1), .ld2(ld2),
    .acc_clr(acc_clr), .y_out(yw_out), .y_valid(yw_valid), .ovf(ovfw)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_ram(input logic [1:0] a, input logic [7:0] d);
    wr = 1'b1; add_ram = a; x_in = d;
    step();
    wr = 1'b0;
  endtask

  task automatic load_pair(input logic [1:0] ra, input logic [1:0] ro);
    ld1 = 1'b1; ld2 = 1'b1; add_ram = ra; add_rom = ro;
    step();
    ld1 = 1'b0; ld2 = 1'b0;
  endtask

  task automatic close_sum();
    acc_clr = 1'b1;
    step();
    acc_clr = 1'b0;
  endtask

  task automatic test_reset();
    global_reset = 1'b1;
    #3;
    checks++;
    if (y_out !== 18'd0 || y_valid !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: y_out=%0d y_valid=%b ovf=%b, required 0/0/0", y_out, y_valid, ovf);
    end
    #4 global_reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      acc_clr = (i % 3 == 1);
      step();
      checks++;
      if (y_out !== 18'd0 || y_valid !== 1'b0 || ovf !== 1'b0) begin
        failures++;
        $display("FAIL idle_%0d: y_out=%0d y_valid=%b ovf=%b, required 0/0/0", i, y_out, y_valid, ovf);
      end
    end
    acc_clr = 1'b0;
  endtask

  task automatic test_mac_sum();
    write_ram(2'd0, 8'd5);
    write_ram(2'd1, 8'd6);
    write_ram(2'd2, 8'd7);
    load_pair(2'd0, 2'd0);
    load_pair(2'd1, 2'd1);
    load_pair(2'd2, 2'd2);
    step();
    step();
    checks++;
    if (y_valid !== 1'b0) begin
      failures++;
      $display("FAIL sum_no_early_pulse: y_valid=%b, required 0", y_valid);
    end
    close_sum();
    checks++;
    if (y_out !== 18'd38 || y_valid !== 1'b1 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL sum_38: y_out=%0d y_valid=%b ovf=%b, required 38/1/0", y_out, y_valid, ovf);
    end
    step();
    checks++;
    if (y_out !== 18'd38 || y_valid !== 1'b0) begin
      failures++;
      $display("FAIL sum_pulse_width: y_out=%0d y_valid=%b, required 38/0", y_out, y_valid);
    end
    close_sum();
    checks++;
    if (y_valid !== 1'b0 || y_out !== 18'd38) begin
      failures++;
      $display("FAIL sum_repeat_clear: y_out=%0d y_valid=%b, required 38/0", y_out, y_valid);
    end
  endtask

  task automatic test_clear_on_last();
    load_pair(2'd0, 2'd0);
    load_pair(2'd1, 2'd1);
    load_pair(2'd2, 2'd2);
    step();
    close_sum();
    checks++;
    if (y_out !== 18'd17 || y_valid !== 1'b1) begin
      failures++;
      $display("FAIL clear_last_17: y_out=%0d y_valid=%b, required 17/1", y_out, y_valid);
    end
    step();
    checks++;
    if (y_valid !== 1'b0) begin
      failures++;
      $display("FAIL clear_last_gap: y_valid=%b, required 0", y_valid);
    end
    close_sum();
    checks++;
    if (y_out !== 18'd21 || y_valid !== 1'b1) begin
      failures++;
      $display("FAIL clear_last_21: y_out=%0d y_valid=%b, required 21/1", y_out, y_valid);
    end
  endtask

  task automatic test_read_before_write();
    wr = 1'b1; x_in = 8'd9; add_ram = 2'd0;
    ld1 = 1'b1; ld2 = 1'b1; add_rom = 2'd0;
    step();
    wr = 1'b0; ld1 = 1'b0; ld2 = 1'b0;
    step();
    step();
    close_sum();
    checks++;
    if (y_out !== 18'd5 || y_valid !== 1'b1) begin
      failures++;
      $display("FAIL rbw_old_word: y_out=%0d y_valid=%b, required 5/1", y_out, y_valid);
    end
    load_pair(2'd0, 2'd0);
    step();
    step();
    close_sum();
    checks++;
    if (y_out !== 18'd9 || y_valid !== 1'b1) begin
      failures++;
      $display("FAIL rbw_new_word: y_out=%0d y_valid=%b, required 9/1", y_out, y_valid);
    end
  endtask

  task automatic test_addr3();
    write_ram(2'd3, 8'd100);
    load_pair(2'd0, 2'd0);
    load_pair(2'd3, 2'd3);
    step();
    step();
    close_sum();
    checks++;
    if (y_out !== 18'd9 || y_valid !== 1'b1) begin
      failures++;
      $display("FAIL addr3_zero_product: y_out=%0d y_valid=%b, required 9/1", y_out, y_valid);
    end
    load_pair(2'd0, 2'd0);
    load_pair(2'd1, 2'd1);
    load_pair(2'd2, 2'd2);
    step();
    step();
    close_sum();
    checks++;
    if (y_out !== 18'd42 || y_valid !== 1'b1) begin
      failures++;
      $display("FAIL addr3_ram_intact: y_out=%0d y_valid=%b, required 42/1", y_out, y_valid);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] exp_w;
`ifdef FIR_MAC_SAT_EN
    exp_w = 16'd32767;
`else
    exp_w = 16'd48387;
`endif
    write_ram(2'd0, 8'd127);
    load_pair(2'd0, 2'd0);
    load_pair(2'd0, 2'd0);
    load_pair(2'd0, 2'd0);
    step();
    step();
    checks++;
    if (ovfw !== 1'b1 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL ovf_flag: ovf_narrow=%b ovf_default=%b, required 1/0", ovfw, ovf);
    end
    close_sum();
    checks++;
    if (yw_out !== exp_w || yw_valid !== 1'b1) begin
      failures++;
      $display("FAIL ovf_sum: y_out_narrow=%0d y_valid=%b, required %0d/1", yw_out, yw_valid, exp_w);
    end
    checks++;
    if (y_out !== 18'd381 || ovfw !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear: y_out=%0d ovf_narrow=%b, required 381/0", y_out, ovfw);
    end
  endtask

  task automatic test_reset_mid_sum();
    load_pair(2'd0, 2'd0);
    load_pair(2'd1, 2'd1);
    #2 global_reset = 1'b1;
    #1;
    checks++;
    if (y_out !== 18'd0 || yw_out !== 16'd0 || y_valid !== 1'b0 || ovf !== 1'b0) begin
      failures++;
      $display("FAIL midsum_reset: y_out=%0d y_out_narrow=%0d y_valid=%b ovf=%b, required 0/0/0/0",
               y_out, yw_out, y_valid, ovf);
    end
    #2 global_reset = 1'b0;
    step();
    close_sum();
    checks++;
    if (y_valid !== 1'b0 || yw_valid !== 1'b0 || y_out !== 18'd0) begin
      failures++;
      $display("FAIL midsum_no_pulse: y_valid=%b y_valid_narrow=%b y_out=%0d, required 0/0/0",
               y_valid, yw_valid, y_out);
    end
    load_pair(2'd0, 2'd0);
    step();
    step();
    close_sum();
    checks++;
    if (y_out !== 18'd0 || y_valid !== 1'b1) begin
      failures++;
      $display("FAIL midsum_ram_cleared: y_out=%0d y_valid=%b, required 0/1", y_out, y_valid);
    end
  endtask

  initial begin
    test_reset();
    test_mac_sum();
    test_clear_on_last();
    test_read_before_write();
    test_addr3();
    test_overflow();
    test_reset_mid_sum();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
